// File: rtl/sd_spi.sv
// sd_spi: SPI master for the SD card slot (mode 0, MSB first).
// Runs INIT (80 dummy clocks), XFER (one byte), and CS assert/deassert
// commands launched by a rising edge on sd_signal.
// Optional feature: define SD_FAST_EN so byte transfers use DIV_FAST;
// INIT always clocks at DIV_SLOW.
module sd_spi #(
  parameter int DIV_SLOW       = 62,
  parameter int DIV_FAST       = 1,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] sd_cmd,
  input  logic [7:0] sd_out,
  input  logic       sd_signal,
  output logic [7:0] sd_din,
  output logic       sd_busy,
  output logic       sd_timeout,
  output logic       spi_cs,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int DW = $clog2(DIV_SLOW + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef SD_FAST_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif
  localparam logic [DW-1:0] SLOW_LIM = DW'(DIV_SLOW);
  localparam logic [DW-1:0] XFER_LIM = FAST_EN ? DW'(DIV_FAST) : DW'(DIV_SLOW);

  typedef enum logic [2:0] {IDLE, CSCTL, SHIFT_LO, SHIFT_HI, DONE} state_t;
  state_t state, state_nx;

  logic          sig_q;
  logic [1:0]    cmd_q;
  logic [6:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic [DW-1:0] div_cnt, div_lim;
  logic [6:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic          accept, phase_end, is_init, last_bit;

  assign accept    = sd_signal & ~sig_q & (state == IDLE);
  assign phase_end = (div_cnt == div_lim - DW'(1));
  assign is_init   = (cmd_q == 2'd0);
  assign last_bit  = (bit_cnt == (is_init ? 7'd79 : 7'd7));
  assign sd_busy    = (state != IDLE);
  assign sd_timeout = (to_cnt == TW'(TIMEOUT_CYCLES));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic: each SCLK half-period is one SHIFT_LO/SHIFT_HI phase
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = (sd_cmd[1]) ? CSCTL : SHIFT_LO;
      CSCTL:    state_nx = DONE;
      SHIFT_LO: if (phase_end) state_nx = SHIFT_HI;
      SHIFT_HI: if (phase_end) state_nx = last_bit ? DONE : SHIFT_LO;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Datapath: command latch, SCLK divider, shift registers and pin drivers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sig_q    <= 1'b0;
      cmd_q    <= 2'd0;
      tx_sh    <= 7'd0;
      rx_sh    <= 8'd0;
      div_cnt  <= '0;
      div_lim  <= SLOW_LIM;
      bit_cnt  <= 7'd0;
      sd_din   <= 8'hFF;
      spi_cs   <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b1;
    end else begin
      sig_q <= sd_signal;
      case (state)
        IDLE: if (accept) begin
          cmd_q   <= sd_cmd;
          tx_sh   <= sd_out[6:0];
          div_cnt <= '0;
          bit_cnt <= 7'd0;
          div_lim <= (sd_cmd == 2'd1) ? XFER_LIM : SLOW_LIM;
          if (sd_cmd == 2'd1) spi_mosi <= sd_out[7];
          if (sd_cmd == 2'd0) begin
            spi_cs   <= 1'b1;
            spi_mosi <= 1'b1;
          end
        end
        // cmd 2 drives CS low, cmd 3 high: the LSB is the pin level
        CSCTL: spi_cs <= cmd_q[0];
        SHIFT_LO: begin
          if (phase_end) begin
            div_cnt  <= '0;
            spi_sclk <= 1'b1;
            rx_sh    <= {rx_sh[6:0], spi_miso};
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            div_cnt  <= '0;
            spi_sclk <= 1'b0;
            bit_cnt  <= bit_cnt + 7'd1;
            if (last_bit) begin
              if (!is_init) sd_din <= rx_sh;
            end else if (!is_init) begin
              spi_mosi <= tx_sh[6];
              tx_sh    <= {tx_sh[5:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        DONE: spi_mosi <= 1'b1;
        default: ;
      endcase
    end
  end

  // Idle timeout: counts only while idle, saturates, cleared by an accept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      to_cnt <= '0;
    else if (accept || state != IDLE)
      to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYCLES))
      to_cnt <= to_cnt + TW'(1);
  end

endmodule

// File: doc/sd_spi.md
# sd_spi

SPI master for the SD card slot, driven by the SD-DAT/SD-CMD I/O registers of the AVR memory controller. It takes a 2-bit command, a data byte and a start strobe from the controller. It runs the transaction on the card's SPI pins, then returns the received byte plus busy and timeout status, which the controller shows in STATUS[5:4] and SD-DAT. It sits between the memory controller and the top-level SD pins, in the CPU clock domain.

## Interface
- DIV_SLOW, 62: clock cycles per SCLK half-period for slow mode (~400 kHz at 50 MHz).
- DIV_FAST, 1: clock cycles per SCLK half-period for fast mode (used only when SD_FAST_EN is defined).
- TIMEOUT_CYCLES, 50000000: idle cycles after which `sd_timeout` is raised.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- sd_cmd  in  2  command: 0 = INIT, 1 = XFER byte, 2 = CS assert (low), 3 = CS deassert (high).
- sd_out  in  8  byte to transmit for XFER.
- sd_signal  in  1  start strobe; a command is launched on its 0→1 transition.
- sd_din  out  8  last received byte.
- sd_busy  out  1  transaction in progress.
- sd_timeout  out  1  no command has been accepted for TIMEOUT_CYCLES idle cycles.
- spi_cs  out  1  card chip select, active-low.
- spi_sclk  out  1  SPI clock, idles low.
- spi_mosi  out  1  master-out data, idles high.
- spi_miso  in  1  master-in data.

## Operation
- SPI mode 0, MSB first:
  - MOSI changes on the falling edge of SCLK, or at transfer start for bit 7.
  - MISO is sampled on the clock edge that drives SCLK high.
- Start detection: `sig_q` holds `sd_signal` from the previous cycle. A command is accepted when `sd_signal & ~sig_q` and the state is IDLE.
  - An edge seen while busy is ignored and not queued. A new edge is required afterwards.
- On accept, `sd_cmd` and `sd_out` are latched and `sd_busy` goes to 1.
- States: IDLE, CSCTL, SHIFT_LO, SHIFT_HI, DONE.
  - **CSCTL (cmd 2/3):** set `spi_cs` to 0 or 1, then go to DONE.
  - **XFER (cmd 1):**
    - `spi_mosi` = bit 7; alternate SHIFT_LO / SHIFT_HI, each phase lasting DIV cycles.
    - At each SHIFT_LO→HI step, SCLK goes high and MISO is shifted into the receive register LSB.
    - After 8 bits, SCLK is low and the shift register is copied to `sd_din`; go to DONE.
    - `spi_cs` is not changed.
  - **INIT (cmd 0):**
    - `spi_cs` = 1 and `spi_mosi` = 1 throughout; 80 SCLK pulses at DIV_SLOW.
    - `sd_din` is unchanged; `spi_cs` stays 1 afterwards.
  - **DONE:** `sd_busy` goes to 0 and `spi_mosi` goes to 1; go to IDLE.
- Timeout counter:
  - Cleared to 0 on every accept; held at 0 while busy.
  - Increments in IDLE and saturates at TIMEOUT_CYCLES.
  - `sd_timeout` = (count == TIMEOUT_CYCLES).
  - An accept clears `sd_timeout` in the same cycle that `sd_busy` rises.
- Reset values: `sd_din` = 8'hFF, `sd_busy` = 0, `sd_timeout` = 0, `spi_cs` = 1, `spi_sclk` = 0, `spi_mosi` = 1, state IDLE, counters 0, `sig_q` = 0.
- Reset asserted mid-transaction forces all reset values immediately. The partial byte is discarded.

## Timing
- Accept at clock edge N: `sd_busy` = 1 after edge N.
- Busy duration (edge N to the edge that clears `sd_busy`):
  - CSCTL: 2 cycles; `spi_cs` changes after edge N+1.
  - XFER: 16·DIV + 1 cycles; `sd_din` is valid in the same cycle `sd_busy` falls.
  - INIT: 160·DIV_SLOW + 1 cycles.
- First SCLK rising edge comes DIV cycles after accept. SCLK duty cycle is exactly 50%.
- A new start strobe is accepted no earlier than the cycle after `sd_busy` falls.

## Configuration
- `SD_FAST_EN` defined: XFER uses DIV_FAST; INIT always uses DIV_SLOW.
- `SD_FAST_EN` undefined: all SCLK timing uses DIV_SLOW, and DIV_FAST is unused.

## Test plan
Bench settings: DIV_SLOW = 4, DIV_FAST = 1, TIMEOUT_CYCLES = 100.
- **Reset:** reset → `spi_cs` = 1, `spi_mosi` = 1, `spi_sclk` = 0, `sd_din` = FF, `sd_busy` = 0.
- **CS assert:** cmd 2 with strobe → `spi_cs` = 0 after 2 cycles, `sd_busy` high for 2 cycles.
- **Byte transfer:** cmd 1, `sd_out` = A5, card model returns 3C (fast mode on) → MOSI bits 1,0,1,0,0,1,0,1; `sd_din` = 3C; busy for 17 cycles.
- **Card init:** cmd 0 → exactly 80 SCLK pulses with CS = 1 and MOSI = 1; busy for 641 cycles; `sd_din` unchanged.
- **Strobe while busy:** strobe during an XFER is ignored; only one byte is clocked; a new strobe after `sd_busy` falls is accepted.
- **Timeout:** idle 100 cycles after DONE → `sd_timeout` = 1; the next accepted strobe clears it. Async reset mid-XFER → all outputs return to reset values at once.
